// File: rtl/collector_pkg.sv
// rtl/collector_pkg.sv - shared types and round-robin helper for the tree arbiters
package collector_pkg;

   typedef enum logic {IDLE, LOCK} coll_state_e;

   localparam int RR_MAX_N = 32;
   localparam int RR_IDX_W = 5;

   // First requester strictly after ptr, wrapping at n; returns ptr when nobody requests.
   function automatic logic [RR_IDX_W-1:0] rr_next(input logic [RR_IDX_W-1:0] ptr,
                                                  input logic [RR_MAX_N-1:0] req,
                                                  input int n);
      logic                found;
      logic [RR_IDX_W-1:0] pos;
      int                  sum;
      rr_next = ptr;
      found   = 1'b0;
      for (int k = 1; k <= RR_MAX_N; k++) begin
         sum = (int'(ptr) + k) % n;
         pos = sum[RR_IDX_W-1:0];
         if (!found && k <= n && req[pos]) begin
            rr_next = pos;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
module rr_pick
   import collector_pkg::*;
#(
   parameter int N  = 5,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic [RR_MAX_N-1:0] req_ext;
   logic [RR_IDX_W-1:0] ptr_ext;
   logic [RR_IDX_W-1:0] pick;

   always_comb begin
      req_ext = RR_MAX_N'(req);
      ptr_ext = RR_IDX_W'(ptr);
      pick    = rr_next(ptr_ext, req_ext, N);
      gnt_idx = IW'(pick);
      gnt_vld = |req;
   end

endmodule

// File: rtl/child_response_collector.sv
// rtl/child_response_collector.sv - merges child response packets upstream, packet-granular round robin
module child_response_collector
   import collector_pkg::*;
#(
   parameter int NUM_CHILDREN = 5,
   parameter int DATA_W       = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CHILDREN-1:0]          in_valid,
   output logic [NUM_CHILDREN-1:0]          in_ready,
   input  logic [NUM_CHILDREN*DATA_W-1:0]   in_data,
   input  logic [NUM_CHILDREN-1:0]          in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_W-1:0]                out_data,
   output logic                             out_last,
   output logic [$clog2(NUM_CHILDREN)-1:0]  out_src,
   output logic                             busy
);

   localparam int IDX_W = $clog2(NUM_CHILDREN);

   coll_state_e        state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   gnt_q, gnt_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic [IDX_W-1:0]   out_src_q, out_src_d;

   logic [IDX_W-1:0]   cand;
   logic               cand_vld;
   logic [IDX_W-1:0]   sel;
   logic               can_load;
   logic               load;
   logic [DATA_W-1:0]  child_data [NUM_CHILDREN];

   always_comb begin
      for (int i = 0; i < NUM_CHILDREN; i++) begin
         child_data[i] = in_data[i*DATA_W +: DATA_W];
      end
   end

   rr_pick #(
      .N  (NUM_CHILDREN),
      .IW (IDX_W)
   ) u_pick (
      .req     (in_valid),
      .ptr     (rr_ptr_q),
      .gnt_idx (cand),
      .gnt_vld (cand_vld)
   );

   always_comb begin
      can_load = !out_valid_q || out_ready;
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = gnt_q;
      in_ready = '0;
      load     = 1'b0;
      sel      = gnt_q;
      case (state_q)
         IDLE: begin
            if (cand_vld && can_load) begin
               in_ready[cand] = 1'b1;
               load           = 1'b1;
               sel            = cand;
               if (in_last[cand]) begin
                  rr_ptr_d = cand;
               end else begin
                  state_d = LOCK;
                  gnt_d   = cand;
               end
            end
         end
         LOCK: begin
            // Granted child owns the port until its last beat, even while it idles.
            in_ready[gnt_q] = can_load;
            if (in_valid[gnt_q] && can_load) begin
               load = 1'b1;
               if (in_last[gnt_q]) begin
                  state_d  = IDLE;
                  rr_ptr_d = gnt_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = child_data[sel];
         out_last_d  = in_last[sel];
         out_src_d   = sel;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= IDX_W'(NUM_CHILDREN - 1);
         gnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;
   assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_child_response_collector.sv
// tb/tb_child_response_collector.sv - directed and scoreboarded checks of child_response_collector
module tb_child_response_collector;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_last;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            out_last;
   logic [IW-1:0]   out_src;
   logic            busy;

   child_response_collector #(.NUM_CHILDREN(N), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      logic [IW-1:0] s;
      int            c;
   } obs_t;

   beat_t        txq  [N][$];
   beat_t        expq [N][$];
   obs_t         obs[$];
   logic [N-1:0] acc;
   int           cyc;
   int           n_cmp;
   int           n_bad;
   logic         sb_on;
   logic         sb_prev_last;
   logic [IW-1:0] sb_prev_src;
   logic         saw_r3;
   logic         last_l [N];
   int           seq;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (txq[i].size() > 0) begin
            in_valid[i]            = 1'b1;
            in_data[i*DW +: DW]    = txq[i][0].d;
            in_last[i]             = txq[i][0].l;
         end else begin
            in_valid[i]            = 1'b0;
            in_data[i*DW +: DW]    = '0;
            in_last[i]             = 1'b0;
         end
      end
   endtask

   task automatic push(input int ch, input logic [DW-1:0] d, input logic l);
      beat_t b;
      b.d = d;
      b.l = l;
      txq[ch].push_back(b);
      if (sb_on) expq[ch].push_back(b);
   endtask

   // Sample on the falling edge, then apply child pops/new heads just after the rising edge.
   task automatic tick();
      obs_t  o;
      beat_t e;
      @(negedge clk);
      cyc++;
      acc = rst ? '0 : (in_valid & in_ready);
      if (!rst) begin
         check_eq("rdy_onehot", 64'($countones(in_ready) <= 1), 64'd1);
         if (busy && in_ready[3]) saw_r3 = 1'b1;
         if (out_valid && out_ready) begin
            if (sb_on) begin
               if (int'(out_src) >= N || expq[out_src].size() == 0) begin
                  check_eq("sb_extra_beat", 64'd1, 64'd0);
               end else begin
                  e = expq[out_src].pop_front();
                  check_eq("sb_data", 64'(out_data), 64'(e.d));
                  check_eq("sb_last", 64'(out_last), 64'(e.l));
               end
               if (!sb_prev_last) check_eq("sb_interleave", 64'(out_src), 64'(sb_prev_src));
               sb_prev_last = out_last;
               sb_prev_src  = out_src;
            end else begin
               o.d = out_data;
               o.l = out_last;
               o.s = out_src;
               o.c = cyc;
               obs.push_back(o);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && txq[i].size() > 0) void'(txq[i].pop_front());
      end
      drive();
      #1;
   endtask

   task automatic wait_obs(input int n, input string tag);
      int k;
      k = 0;
      while (obs.size() < n && k < 200) begin
         tick();
         k++;
      end
      check_eq({tag, "_timeout"}, 64'(obs.size() >= n), 64'd1);
   endtask

   task automatic chk_obs(input int idx, input string tag, input logic [DW-1:0] d,
                          input logic l, input logic [IW-1:0] s);
      if (obs.size() > idx) begin
         check_eq({tag, "_data"}, 64'(obs[idx].d), 64'(d));
         check_eq({tag, "_last"}, 64'(obs[idx].l), 64'(l));
         check_eq({tag, "_src"},  64'(obs[idx].s), 64'(s));
      end else begin
         check_eq({tag, "_missing"}, 64'd0, 64'd1);
      end
   endtask

   initial begin
      int k;
      logic done;
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      seq   = 0;
      sb_on = 1'b0;
      sb_prev_last = 1'b1;
      sb_prev_src  = '0;
      saw_r3 = 1'b0;
      acc   = '0;
      rst   = 1'b1;
      out_ready = 1'b1;
      drive();
      repeat (3) tick();
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_data",  64'(out_data),  64'd0);
      check_eq("rst_out_last",  64'(out_last),  64'd0);
      check_eq("rst_out_src",   64'(out_src),   64'd0);
      check_eq("rst_busy",      64'(busy),      64'd0);
      rst = 1'b0;
      tick();

      // single-beat packets from 0,2,4 (child 0 has two): order 0,2,4,0 back to back
      push(0, 32'h100, 1'b1);
      push(0, 32'h101, 1'b1);
      push(2, 32'h200, 1'b1);
      push(4, 32'h400, 1'b1);
      wait_obs(4, "t1");
      chk_obs(0, "t1_b0", 32'h100, 1'b1, 3'd0);
      chk_obs(1, "t1_b1", 32'h200, 1'b1, 3'd2);
      chk_obs(2, "t1_b2", 32'h400, 1'b1, 3'd4);
      chk_obs(3, "t1_b3", 32'h101, 1'b1, 3'd0);
      if (obs.size() >= 4) begin
         check_eq("t1_gap01", 64'(obs[1].c - obs[0].c), 64'd1);
         check_eq("t1_gap12", 64'(obs[2].c - obs[1].c), 64'd1);
         check_eq("t1_gap23", 64'(obs[3].c - obs[2].c), 64'd1);
      end
      obs.delete();

      // 3-beat packet from child 1 holds off child 3
      saw_r3 = 1'b0;
      push(1, 32'h110, 1'b0);
      push(1, 32'h111, 1'b0);
      push(1, 32'h112, 1'b1);
      push(3, 32'h330, 1'b1);
      wait_obs(4, "t2");
      chk_obs(0, "t2_b0", 32'h110, 1'b0, 3'd1);
      chk_obs(1, "t2_b1", 32'h111, 1'b0, 3'd1);
      chk_obs(2, "t2_b2", 32'h112, 1'b1, 3'd1);
      chk_obs(3, "t2_b3", 32'h330, 1'b1, 3'd3);
      check_eq("t2_r3_blocked", 64'(saw_r3), 64'd0);
      obs.delete();

      // upstream stall for 4 cycles, then release with a same-cycle reload
      out_ready = 1'b0;
      push(0, 32'h500, 1'b1);
      push(2, 32'h520, 1'b1);
      tick();
      tick();
      for (int c = 0; c < 4; c++) begin
         check_eq("t3_hold_valid", 64'(out_valid), 64'd1);
         check_eq("t3_hold_data",  64'(out_data),  64'h500);
         check_eq("t3_hold_src",   64'(out_src),   64'd0);
         check_eq("t3_hold_last",  64'(out_last),  64'd1);
         check_eq("t3_hold_rdy",   64'(in_ready),  64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check_eq("t3_reload_valid", 64'(out_valid), 64'd1);
      check_eq("t3_reload_data",  64'(out_data),  64'h520);
      check_eq("t3_reload_src",   64'(out_src),   64'd2);
      chk_obs(0, "t3_accept", 32'h500, 1'b1, 3'd0);
      wait_obs(2, "t3");
      obs.delete();

      // rr_ptr left at 4, then 4 and 0 compete: wrap gives child 0 first
      push(4, 32'h640, 1'b1);
      wait_obs(1, "t4a");
      chk_obs(0, "t4_setup", 32'h640, 1'b1, 3'd4);
      obs.delete();
      push(0, 32'h600, 1'b1);
      push(4, 32'h641, 1'b1);
      wait_obs(2, "t4");
      chk_obs(0, "t4_b0", 32'h600, 1'b1, 3'd0);
      chk_obs(1, "t4_b1", 32'h641, 1'b1, 3'd4);
      obs.delete();

      // reset during beat 2 of a 4-beat packet
      push(0, 32'hA00, 1'b0);
      push(0, 32'hA01, 1'b0);
      push(0, 32'hA02, 1'b0);
      push(0, 32'hA03, 1'b1);
      push(2, 32'h7A0, 1'b1);
      tick();
      tick();
      check_eq("t5_busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      for (int i = 0; i < N; i++) txq[i].delete();
      tick();
      check_eq("t5_valid_post", 64'(out_valid), 64'd0);
      check_eq("t5_busy_post",  64'(busy),      64'd0);
      rst = 1'b0;
      obs.delete();
      push(2, 32'h7C0, 1'b1);
      push(0, 32'hB00, 1'b1);
      wait_obs(2, "t5");
      chk_obs(0, "t5_b0", 32'hB00, 1'b1, 3'd0);
      chk_obs(1, "t5_b1", 32'h7C0, 1'b1, 3'd2);
      obs.delete();

      // random traffic against per-source scoreboard
      sb_on = 1'b1;
      sb_prev_last = 1'b1;
      for (int i = 0; i < N; i++) last_l[i] = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (txq[i].size() < 4 && $urandom_range(0, 2) == 0) begin
               seq++;
               last_l[i] = ($urandom_range(0, 2) == 0);
               push(i, {8'(i), 24'(seq)}, last_l[i]);
            end
         end
         tick();
      end
      for (int i = 0; i < N; i++) begin
         if (!last_l[i]) begin
            seq++;
            push(i, {8'(i), 24'(seq)}, 1'b1);
         end
      end
      out_ready = 1'b1;
      k = 0;
      done = 1'b0;
      while (!done && k < 500) begin
         tick();
         k++;
         done = !out_valid && !busy;
         for (int i = 0; i < N; i++) if (txq[i].size() > 0) done = 1'b0;
      end
      check_eq("sb_drain_timeout", 64'(done), 64'd1);
      for (int i = 0; i < N; i++) check_eq("sb_lost_beats", 64'(expq[i].size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
